updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
//
// PURPOSE
//   Parametrised up/down counter: successor to the fixed 4-bit down counter.
//   Adds direction select, count enable, synchronous parallel load, a programmable
//   modulus, and wrap-or-saturate mode, with boundary flags and a one-cycle wrap pulse.
//   Used as a timer/event counter building block in the challenge designs.
//
// PARAMETERS
//   WIDTH      4               counter width in bits (>=2)
//   MAX_COUNT  (1<<WIDTH)-1    highest count value; range is 0..MAX_COUNT
//   RESET_VAL  MAX_COUNT       q value on reset; must be <= MAX_COUNT
//   SATURATE   0               0 = wrap at bounds, 1 = hold at bounds
//   PRESCALE   4               enabled cycles per step (used only with UDC_PRESCALE_EN)
//
// PORTS
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value to load
//   q         out  WIDTH  current count (registered)
//   at_min    out  1      q == 0 (decoded from q)
//   at_max    out  1      q == MAX_COUNT (decoded from q)
//   wrap      out  1      registered 1-cycle pulse: the step just taken crossed a bound
//
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): q=RESET_VAL, wrap=0, prescaler=0. At_min/at_max
//     follow q. Mid-count reset is honoured immediately; counting resumes on the first
//     rising edge after reset=1.
//   - Priority per rising edge: load > step > hold.
//   - load=1: q <= min(load_val, MAX_COUNT); wrap <= 0; prescaler cleared; en ignored.
//   - Step (load=0, en=1, and prescaler tick): 1-cycle latency, edge to q.
//       up, q<MAX_COUNT: q+1.  up, q==MAX_COUNT: SATURATE ? hold : q=0, wrap=1.
//       down, q>0: q-1.        down, q==0: SATURATE ? hold : q=MAX_COUNT, wrap=1.
//   - Saturate mode never asserts wrap.
//   - en=0 and load=0: q holds; wrap <= 0.
//   - wrap is high for exactly one cycle per wrapping step; back-to-back wraps
//     (e.g. MAX_COUNT=1) give wrap high on consecutive cycles.
//   - up_dn may change on any cycle; takes effect on the next step.
//   - Arithmetic in WIDTH bits; MAX_COUNT < 2**WIDTH-1 gives modulo-(MAX_COUNT+1).
//
// CONFIGURATION
//   UDC_PRESCALE_EN defined: internal counter of ceil(log2(PRESCALE)) bits counts
//     enabled cycles; a step occurs only on the enabled cycle where it reaches
//     PRESCALE-1 (then clears). en=0 freezes the prescaler. load clears it.
//   UDC_PRESCALE_EN undefined: every enabled cycle is a step; PRESCALE is unused.
//
// TESTING (WIDTH=4, MAX_COUNT=9, RESET_VAL=9 unless stated)
//   1 reset=0 then release, en=1, up_dn=0 for 12 cycles -> q 9,8..0,9,8; wrap=1 one cycle at 0->9.
//   2 SATURATE=1, up_dn=1, load 7 then en=1 for 5 cycles -> q 7,8,9,9,9; wrap never high.
//   3 load=1, load_val=15 with en=1 -> q=9 next edge (clamped), wrap=0.
//   4 q=5, en=1, toggle up_dn each cycle -> q 6,5,6,5; en=0 -> q holds.
//   5 reset=0 asserted mid-cycle while q=3 -> q=9 before next edge, wrap=0.
//   6 UDC_PRESCALE_EN, PRESCALE=4, down from 9, en=1 -> q steps every 4th cycle.

Source files
------------

// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if
//   Control/status bundle for updown_counter_param.
//   master : drives en, up_dn, load, load_val; observes q, at_min, at_max, wrap
//   slave  : the counter itself
//   Parameter WIDTH must match the WIDTH of the attached counter.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             at_min;
    logic             at_max;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  q, at_min, at_max, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, at_min, at_max, wrap
    );
endinterface

// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter with count enable, synchronous clamped load,
//   programmable modulus (0..MAX_COUNT), wrap-or-saturate at the bounds,
//   boundary flags and a registered one-cycle wrap pulse.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (q=RESET_VAL, wrap=0, prescaler=0)
//   bus    : slave modport of updown_counter_param_if
//            en, up_dn, load, load_val in; q, at_min, at_max, wrap out
//
// Optional feature
//   UDC_PRESCALE_EN : when defined, a step is taken only on every PRESCALE-th
//                     enabled cycle; otherwise every enabled cycle steps.
module updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter int RESET_VAL = MAX_COUNT,
    parameter int SATURATE  = 0,
    parameter int PRESCALE  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be >= 2");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
        $error("updown_counter_param: MAX_COUNT out of range");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_reset
        $error("updown_counter_param: RESET_VAL must be <= MAX_COUNT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter_param: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick;

`ifdef UDC_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Prescaler only advances on enabled, non-load cycles; it rolls over on
    // the same cycle it grants a step.
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (bus.load) begin
            pre_d = '0;
        end else if (bus.en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = bus.en;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            cnt_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (bus.en && tick) begin
            if (bus.up_dn) begin
                if (cnt_q != MAX_V) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= RST_V;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q      = cnt_q;
    assign bus.wrap   = wrap_q;
    assign bus.at_min = (cnt_q == '0);
    assign bus.at_max = (cnt_q == MAX_V);
endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;
    localparam int W    = 4;
    localparam int MAXC = 9;
    localparam int RSTV = 9;
    localparam int PS   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(W)) bw ();
    updown_counter_param_if #(.WIDTH(W)) bs ();

    updown_counter_param #(
        .WIDTH(W), .MAX_COUNT(MAXC), .RESET_VAL(RSTV), .SATURATE(0), .PRESCALE(PS)
    ) dut_w (
        .clk(clk), .reset(reset), .bus(bw)
    );

    updown_counter_param #(
        .WIDTH(W), .MAX_COUNT(MAXC), .RESET_VAL(RSTV), .SATURATE(1), .PRESCALE(PS)
    ) dut_s (
        .clk(clk), .reset(reset), .bus(bs)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = wrapping counter, 1 = saturating counter.
    int mq  [2];
    int mw  [2];
    int mpre[2];

    typedef struct {
        bit         en;
        bit         up;
        bit         ld;
        logic [3:0] lv;
        int         qw;
        int         ww;
        int         qs;
        int         ws;
    } vec_t;

    vec_t tbl [30];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_pair(input string tag, input int qw, input int ww,
                              input int qs, input int ws);
        cmp({tag, " w.q"},      32'(bw.q),      32'(qw));
        cmp({tag, " w.wrap"},   32'(bw.wrap),   32'(ww));
        cmp({tag, " w.at_min"}, 32'(bw.at_min), 32'(qw == 0));
        cmp({tag, " w.at_max"}, 32'(bw.at_max), 32'(qw == MAXC));
        cmp({tag, " s.q"},      32'(bs.q),      32'(qs));
        cmp({tag, " s.wrap"},   32'(bs.wrap),   32'(ws));
        cmp({tag, " s.at_min"}, 32'(bs.at_min), 32'(qs == 0));
        cmp({tag, " s.at_max"}, 32'(bs.at_max), 32'(qs == MAXC));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i]   = RSTV;
            mw[i]   = 0;
            mpre[i] = 0;
        end
    endfunction

    // Counting on the ring 0..MAXC: a step leaving the range is a bound crossing.
    function automatic void model_edge(input int i, input bit en, input bit up,
                                       input bit ld, input int lv);
        bit go;
        int nxt;
        mw[i] = 0;
        if (ld) begin
            mq[i]   = (lv > MAXC) ? MAXC : lv;
            mpre[i] = 0;
        end else if (en) begin
`ifdef UDC_PRESCALE_EN
            mpre[i] = (mpre[i] + 1) % PS;
            go = (mpre[i] == 0);
`else
            go = 1'b1;
`endif
            if (go) begin
                nxt = up ? mq[i] + 1 : mq[i] - 1;
                if (nxt >= 0 && nxt <= MAXC) begin
                    mq[i] = nxt;
                end else if (i == 0) begin
                    mq[i] = (nxt + MAXC + 1) % (MAXC + 1);
                    mw[i] = 1;
                end
            end
        end
    endfunction

    task automatic drive(input bit en, input bit up, input bit ld, input logic [3:0] lv);
        bw.en = en; bw.up_dn = up; bw.load = ld; bw.load_val = lv;
        bs.en = en; bs.up_dn = up; bs.load = ld; bs.load_val = lv;
    endtask

    task automatic cyc(input string tag, input bit en, input bit up, input bit ld,
                       input logic [3:0] lv);
        drive(en, up, ld, lv);
        @(posedge clk);
        model_edge(0, en, up, ld, int'(lv));
        model_edge(1, en, up, ld, int'(lv));
        #1;
        check_pair(tag, mq[0], mw[0], mq[1], mw[1]);
    endtask

    // Called 1 time unit after a rising edge: reset lands mid-cycle.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_pair(tag, RSTV, 0, RSTV, 0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        tbl = '{
            '{1, 0, 0, 0,  8, 0, 8, 0},
            '{1, 0, 0, 0,  7, 0, 7, 0},
            '{1, 0, 0, 0,  6, 0, 6, 0},
            '{1, 0, 0, 0,  5, 0, 5, 0},
            '{1, 0, 0, 0,  4, 0, 4, 0},
            '{1, 0, 0, 0,  3, 0, 3, 0},
            '{1, 0, 0, 0,  2, 0, 2, 0},
            '{1, 0, 0, 0,  1, 0, 1, 0},
            '{1, 0, 0, 0,  0, 0, 0, 0},
            '{1, 0, 0, 0,  9, 1, 0, 0},
            '{1, 0, 0, 0,  8, 0, 0, 0},
            '{1, 0, 1, 15, 9, 0, 9, 0},
            '{0, 1, 1, 7,  7, 0, 7, 0},
            '{1, 1, 0, 0,  8, 0, 8, 0},
            '{1, 1, 0, 0,  9, 0, 9, 0},
            '{1, 1, 0, 0,  0, 1, 9, 0},
            '{1, 1, 0, 0,  1, 0, 9, 0},
            '{0, 0, 1, 5,  5, 0, 5, 0},
            '{1, 1, 0, 0,  6, 0, 6, 0},
            '{1, 0, 0, 0,  5, 0, 5, 0},
            '{1, 1, 0, 0,  6, 0, 6, 0},
            '{1, 0, 0, 0,  5, 0, 5, 0},
            '{0, 1, 0, 0,  5, 0, 5, 0},
            '{0, 1, 0, 0,  5, 0, 5, 0},
            '{0, 0, 1, 0,  0, 0, 0, 0},
            '{0, 0, 0, 0,  0, 0, 0, 0},
            '{1, 0, 0, 0,  9, 1, 0, 0},
            '{1, 1, 0, 0,  0, 1, 1, 0},
            '{1, 1, 1, 3,  3, 0, 3, 0},
            '{0, 1, 0, 9,  3, 0, 3, 0}
        };

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        #12;
        check_pair("reset", RSTV, 0, RSTV, 0);
        reset = 1'b1;

`ifndef UDC_PRESCALE_EN
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv);
            @(posedge clk);
            #1;
            check_pair($sformatf("vec%0d", i), tbl[i].qw, tbl[i].ww, tbl[i].qs, tbl[i].ws);
        end
        // q is 3 here; reset must take effect before the next edge.
        mid_reset("midreset");
`else
        // Counting down from 9: one step per PRESCALE enabled cycles.
        for (int k = 1; k <= 12; k++) begin
            cyc("prescale", 1'b1, 1'b0, 1'b0, 4'd0);
            cmp("prescale.const", 32'(bw.q), 32'(RSTV - k / PS));
        end
        cyc("prescale.freeze", 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("prescale.load", 1'b1, 1'b0, 1'b1, 4'd5);
        mid_reset("midreset");
`endif

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset("rand.reset");
            end else begin
                cyc("rand",
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 11) == 0),
                    4'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
